// File: rtl/regfile_mrd_1wr.sv
// regfile_mrd_1wr: DEPTH x WIDTH register file with one write port and NUM_RD
// registered read ports. Define REGFILE_WR_BYPASS_EN to forward same-edge write data.

module mux2 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

module D_FF #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

module regfile_mrd_1wr #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 3,
  parameter  int ZERO_REG = 31,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid
);
  localparam bit HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  genvar gi, gn;

  // The hardwired-zero index has no storage at all, so writes to it vanish.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_reg
      if (HAS_ZERO && gi == ZERO_REG) begin : gen_zero
        assign regs[gi] = '0;
      end else begin : gen_store
        logic             we;
        logic [WIDTH-1:0] d;
        assign we = wr_en && (wr_addr == ADDR_W'(gi));
        mux2 #(.W(WIDTH)) u_en_mux (
          .sel (we),
          .a   (regs[gi]),
          .b   (wr_data),
          .y   (d)
        );
        D_FF #(.W(WIDTH)) u_ff (
          .clk   (clk),
          .reset (reset),
          .d     (d),
          .q     (regs[gi])
        );
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : gen_port
      // Heap-ordered tree: leaves at DEPTH..2*DEPTH-1, root at 1; level L uses address bit ADDR_W-1-L.
      logic [WIDTH-1:0] node [1:2*DEPTH-1];
      logic [WIDTH-1:0] read_val;
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;

      for (gn = 0; gn < DEPTH; gn++) begin : gen_leaf
        assign node[DEPTH+gn] = regs[gn];
      end

      for (gn = 1; gn < DEPTH; gn++) begin : gen_node
        localparam int LEVEL = $clog2(gn + 1) - 1;
        mux2 #(.W(WIDTH)) u_mux (
          .sel (rd_addr[gi][ADDR_W-1-LEVEL]),
          .a   (node[2*gn]),
          .b   (node[2*gn+1]),
          .y   (node[gn])
        );
      end

`ifdef REGFILE_WR_BYPASS_EN
      logic hit;
      assign hit = wr_en && (wr_addr == rd_addr[gi]) &&
                   !(HAS_ZERO && (wr_addr == ADDR_W'(ZERO_REG)));
      mux2 #(.W(WIDTH)) u_bypass (
        .sel (hit),
        .a   (node[1]),
        .b   (wr_data),
        .y   (read_val)
      );
`else
      assign read_val = node[1];
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= rd_en[gi];
          if (rd_en[gi]) data_reg <= read_val;
        end
      end

      assign rd_data[gi]  = data_reg;
      assign rd_valid[gi] = valid_reg;
    end
  endgenerate
endmodule
